// File: rtl/sync_fifo_if.sv
// Producer/consumer signal bundle for sync_fifo.
// The signal names match the flat ports of the original module.
interface sync_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  write_en_i;
    logic                  read_en_i;
    logic [DATA_WIDTH-1:0] write_data_i;
    logic [DATA_WIDTH-1:0] read_data_o;
    logic                  empty_o;
    logic                  full_o;

    modport master (
        output write_en_i, read_en_i, write_data_i,
        input  read_data_o, empty_o, full_o
    );

    modport slave (
        input  write_en_i, read_en_i, write_data_i,
        output read_data_o, empty_o, full_o
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and registered empty/full flags.
// Writes to a full FIFO and reads from an empty FIFO are dropped without side effects.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    sync_fifo_if.slave fifo
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  wr_acc, rd_acc;

    // Acceptance uses the registered flags, i.e. the state before this edge.
    always_comb begin
        wr_acc    = fifo.write_en_i && !full_q;
        rd_acc    = fifo.read_en_i && !empty_q;
        wr_ptr_d  = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        rd_data_d = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
        count_d   = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_CNT);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
        end
    end

    // Storage is not reset; a write coinciding with reset is discarded.
    always_ff @(posedge clk_i) begin
        if (wr_acc && !reset_i) begin
            mem_q[wr_ptr_q] <= fifo.write_data_i;
        end
    end

    assign fifo.read_data_o = rd_data_q;
    assign fifo.empty_o     = empty_q;
    assign fifo.full_o      = full_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: each stimulus cycle queues its hand-derived
// expected outputs, and a negedge monitor pops and compares them.
module tb_sync_fifo;
    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        int          due;
        logic [7:0]  data;
        logic        empty;
        logic        full;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    sync_fifo_if #(.DATA_WIDTH(8)) bus ();

    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .fifo    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".read_data"}, int'(bus.read_data_o), int'(e.data));
            chk({e.tag, ".empty"},     int'(bus.empty_o),     int'(e.empty));
            chk({e.tag, ".full"},      int'(bus.full_o),      int'(e.full));
        end
    end

    // One clock of stimulus plus the outputs expected right after that edge.
    task automatic step(input logic r, input logic we, input logic re, input logic [7:0] wd,
                        input logic [7:0] ed, input logic ee, input logic ef, input string tag);
        @(negedge clk);
        rst              = r;
        bus.write_en_i   = we;
        bus.read_en_i    = re;
        bus.write_data_i = wd;
        exp_q.push_back('{due: cyc + 1, data: ed, empty: ee, full: ef, tag: tag});
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst              = 1'b1;
        bus.write_en_i   = 1'b0;
        bus.read_en_i    = 1'b0;
        bus.write_data_i = 8'h00;

        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 8'h00, 1, 0, "reset");

        step(0, 1, 0, 8'hA5, 8'h00, 0, 0, "single_wr");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 8'h00, 0, 0, "single_idle");
        step(0, 0, 1, 8'h00, 8'hA5, 1, 0, "single_rd");
        step(0, 0, 1, 8'h00, 8'hA5, 1, 0, "single_underflow");

        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(i), 8'hA5, 0, (i == 15), "fill1_wr");
        step(0, 1, 0, 8'hFF, 8'hA5, 0, 1, "fill1_overflow");
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'h00, 8'(i), (i == 15), 0, "fill1_rd");
        step(0, 0, 0, 8'h00, 8'h0F, 1, 0, "fill1_idle");

        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'h10 + i), 8'h0F, 0, (i == 15), "fill2_wr");
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'h00, 8'(8'h10 + i), (i == 15), 0, "fill2_rd");

        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'h20 + i), 8'h1F, 0, 0, "both_prefill");
        for (int i = 0; i < 4; i++) step(0, 1, 1, 8'(8'h23 + i), 8'(8'h20 + i), 0, 0, "both_mid");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00, 8'(8'h24 + i), (i == 2), 0, "both_drain");

        step(0, 1, 1, 8'h30, 8'h26, 0, 0, "both_empty");
        step(0, 0, 1, 8'h00, 8'h30, 1, 0, "both_empty_rd");

        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'h40 + i), 8'h30, 0, (i == 15), "full_fill");
        step(0, 1, 1, 8'h99, 8'h40, 0, 0, "both_full");
        for (int i = 0; i < 15; i++) step(0, 0, 1, 8'h00, 8'(8'h41 + i), (i == 14), 0, "both_full_drain");

        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h50 + i), 8'h4F, 0, 0, "mid_wr");
        step(1, 1, 1, 8'h77, 8'h00, 1, 0, "mid_reset");
        step(0, 1, 0, 8'h3C, 8'h00, 0, 0, "post_reset_wr");
        step(0, 0, 1, 8'h00, 8'h3C, 1, 0, "post_reset_rd");

        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'h00, 8'h3C, 1, 0, "guard_underflow");
        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'h60 + i), 8'h3C, 0, (i == 15), "guard_fill");
        for (int i = 0; i < 10; i++) step(0, 1, 0, 8'hEE, 8'h3C, 0, 1, "guard_overflow");
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'h00, 8'(8'h60 + i), (i == 15), 0, "guard_drain");

        @(negedge clk);
        bus.write_en_i = 1'b0;
        bus.read_en_i  = 1'b0;
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
